// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the IF/MEM requesters, the memory arbiter and the unified memory.
// The arbiter takes the slave view and the requesters/memory model the master view.
interface mem_port_arbiter_if #(
  parameter int AW = 9,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          if_stall;
  logic          d_req;
  logic          d_rw;
  logic [1:0]    d_size;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          d_stall;
  logic          m_en;
  logic          m_rw;
  logic [1:0]    m_size;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_rw, d_size, d_addr, d_wdata, m_rdata,
    output if_ack, if_rdata, if_stall, d_ack, d_rdata, d_stall,
    output m_en, m_rw, m_size, m_addr, m_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_rw, d_size, d_addr, d_wdata, m_rdata,
    input  if_ack, if_rdata, if_stall, d_ack, d_rdata, d_stall,
    input  m_en, m_rw, m_size, m_addr, m_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data load/store.
// Define ARB_PERF_EN to add the conflict_cnt / forced_cnt performance counters.
module mem_port_arbiter #(
  parameter int AW         = 9,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef ARB_PERF_EN
  output logic [15:0]           conflict_cnt,
  output logic [15:0]           forced_cnt,
`endif
  mem_port_arbiter_if.slave     bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_e;

  localparam logic [3:0] LAT_INIT   = 4'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_e        state_q, state_d;
  logic [3:0]    lat_cnt_q, lat_cnt_d;
  logic [3:0]    starve_cnt_q, starve_cnt_d;
  logic          sel_fetch_q, sel_fetch_d;
  logic          m_en_q, m_en_d;
  logic          m_rw_q, m_rw_d;
  logic [1:0]    m_size_q, m_size_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic [DW-1:0] m_wdata_q, m_wdata_d;
  logic          if_ack_q, if_ack_d;
  logic          d_ack_q, d_ack_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          grant_fetch;
  logic          forced_evt;

  always_comb begin
    state_d      = state_q;
    lat_cnt_d    = lat_cnt_q;
    starve_cnt_d = starve_cnt_q;
    sel_fetch_d  = sel_fetch_q;
    m_en_d       = m_en_q;
    m_rw_d       = m_rw_q;
    m_size_d     = m_size_q;
    m_addr_d     = m_addr_q;
    m_wdata_d    = m_wdata_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    if_ack_d     = 1'b0;
    d_ack_d      = 1'b0;
    grant_fetch  = 1'b0;
    forced_evt   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.if_req || bus.d_req) begin
          // Data wins contention until fetch has lost STARVE_MAX times in a row.
          grant_fetch = bus.if_req && (!bus.d_req || starve_cnt_q == STARVE_LIM);
          forced_evt  = bus.if_req && bus.d_req && starve_cnt_q == STARVE_LIM;
          if (grant_fetch) begin
            m_rw_d   = 1'b0;
            m_size_d = 2'b10;
            m_addr_d = bus.if_addr;
          end else begin
            m_rw_d    = bus.d_rw;
            m_size_d  = bus.d_size;
            m_addr_d  = bus.d_addr;
            m_wdata_d = bus.d_wdata;
          end
          starve_cnt_d = (bus.if_req && !grant_fetch) ? starve_cnt_q + 4'd1 : 4'd0;
          sel_fetch_d  = grant_fetch;
          m_en_d       = 1'b1;
          lat_cnt_d    = LAT_INIT;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        if (lat_cnt_q != 4'd0) begin
          lat_cnt_d = lat_cnt_q - 4'd1;
        end else begin
          if (!m_rw_q) begin
            if (sel_fetch_q) if_rdata_d = bus.m_rdata;
            else             d_rdata_d  = bus.m_rdata;
          end
          m_en_d   = 1'b0;
          m_rw_d   = 1'b0;
          if_ack_d = sel_fetch_q;
          d_ack_d  = !sel_fetch_q;
          state_d  = ACK;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      lat_cnt_q    <= '0;
      starve_cnt_q <= '0;
      sel_fetch_q  <= 1'b0;
      m_en_q       <= 1'b0;
      m_rw_q       <= 1'b0;
      m_size_q     <= '0;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
      if_ack_q     <= 1'b0;
      d_ack_q      <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      sel_fetch_q  <= sel_fetch_d;
      m_en_q       <= m_en_d;
      m_rw_q       <= m_rw_d;
      m_size_q     <= m_size_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
      if_ack_q     <= if_ack_d;
      d_ack_q      <= d_ack_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

`ifdef ARB_PERF_EN
  logic [15:0] conflict_cnt_q, conflict_cnt_d;
  logic [15:0] forced_cnt_q, forced_cnt_d;

  // Both counters stick at all-ones rather than wrapping.
  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    forced_cnt_d   = forced_cnt_q;
    if (bus.if_req && bus.d_req && conflict_cnt_q != 16'hFFFF)
      conflict_cnt_d = conflict_cnt_q + 16'd1;
    if (forced_evt && forced_cnt_q != 16'hFFFF)
      forced_cnt_d = forced_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      conflict_cnt_q <= '0;
      forced_cnt_q   <= '0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
      forced_cnt_q   <= forced_cnt_d;
    end
  end

  assign conflict_cnt = conflict_cnt_q;
  assign forced_cnt   = forced_cnt_q;
`else
  logic unused_forced;
  assign unused_forced = forced_evt;
`endif

  assign bus.m_en     = m_en_q;
  assign bus.m_rw     = m_rw_q;
  assign bus.m_size   = m_size_q;
  assign bus.m_addr   = m_addr_q;
  assign bus.m_wdata  = m_wdata_q;
  assign bus.if_ack   = if_ack_q;
  assign bus.d_ack    = d_ack_q;
  assign bus.if_rdata = if_rdata_q;
  assign bus.d_rdata  = d_rdata_q;
  assign bus.if_stall = bus.if_req & ~if_ack_q;
  assign bus.d_stall  = bus.d_req & ~d_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected acks, a monitor pops them.
// With ARB_PERF_EN defined the forced-fetch counter is also checked.
module tb_mem_port_arbiter;
  localparam int AW         = 9;
  localparam int DW         = 32;
  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 4;

  typedef struct {
    bit          is_data;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus();

`ifdef ARB_PERF_EN
  logic [15:0] conflict_cnt;
  logic [15:0] forced_cnt;
`endif

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk          (clk),
    .reset        (reset),
`ifdef ARB_PERF_EN
    .conflict_cnt (conflict_cnt),
    .forced_cnt   (forced_cnt),
`endif
    .bus          (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Small memory image with hand-picked contents at the addresses the tests use.
  function automatic logic [31:0] memRead(input logic [8:0] a);
    case (a)
      9'h004:  return 32'h11112222;
      9'h008:  return 32'h33334444;
      9'h010:  return 32'h8C220004;
      9'h030:  return 32'hCAFE0030;
      default: return 32'h0BAD0000 | 32'(a);
    endcase
  endfunction

  assign bus.m_rdata = memRead(bus.m_addr);

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input bit ifr, input logic [8:0] ia, input bit dr, input bit rw,
                               input logic [1:0] sz, input logic [8:0] da, input logic [31:0] wd,
                               output int c);
    @(posedge clk);
    #1;
    bus.if_req  = ifr;
    bus.if_addr = ia;
    bus.d_req   = dr;
    bus.d_rw    = rw;
    bus.d_size  = sz;
    bus.d_addr  = da;
    bus.d_wdata = wd;
    c = cyc;
  endtask

  task automatic expectAck(input bit is_data, input logic [31:0] rdata, input int at);
    exp_t e;
    e.is_data = is_data;
    e.rdata   = rdata;
    e.cyc     = at;
    sb.push_back(e);
  endtask

  task automatic waitAck(input bit is_data);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (is_data ? bus.d_ack : bus.if_ack) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL ack_timeout: got no %s ack within 40 cycles, required one", is_data ? "data" : "fetch");
    end
  endtask

  // Monitor: every ack presented by the DUT is matched against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (bus.if_ack || bus.d_ack) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_ack: got if_ack=%0b d_ack=%0b at cycle %0d, required none",
                 bus.if_ack, bus.d_ack, cyc);
      end else begin
        e = sb.pop_front();
        checkOutput("ack_kind", {62'd0, bus.if_ack, bus.d_ack}, e.is_data ? 64'd1 : 64'd2);
        checkOutput("ack_cycle", 64'(cyc), 64'(e.cyc));
        checkOutput("ack_rdata", e.is_data ? 64'(bus.d_rdata) : 64'(bus.if_rdata), 64'(e.rdata));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c;
    reset       = 1'b1;
    bus.if_req  = 1'b1;
    bus.if_addr = 9'h008;
    bus.d_req   = 1'b1;
    bus.d_rw    = 1'b0;
    bus.d_size  = 2'b10;
    bus.d_addr  = 9'h004;
    bus.d_wdata = 32'h0;

    // Reset with both requests high: everything quiet.
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("rst_m_en", bus.m_en, 0);
      checkOutput("rst_m_rw", bus.m_rw, 0);
      checkOutput("rst_m_size", bus.m_size, 0);
      checkOutput("rst_m_addr", bus.m_addr, 0);
      checkOutput("rst_m_wdata", bus.m_wdata, 0);
      checkOutput("rst_acks", {bus.if_ack, bus.d_ack}, 0);
      checkOutput("rst_if_rdata", bus.if_rdata, 0);
      checkOutput("rst_d_rdata", bus.d_rdata, 0);
    end
    reset = 1'b0;
    c = cyc;
    expectAck(1'b1, 32'h11112222, c + 3);
    waitAck(1'b1);
    applyStimulus(0, 9'h0, 0, 0, 2'b00, 9'h0, 32'h0, c);

    // Lone fetch: timing of m_en and if_stall.
    applyStimulus(1, 9'h010, 0, 0, 2'b00, 9'h0, 32'h0, c);
    expectAck(1'b0, 32'h8C220004, c + 3);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("fetch_if_stall", bus.if_stall, 64'(k < 3));
      checkOutput("fetch_m_en", bus.m_en, 64'(k == 1 || k == 2));
      if (k == 1 || k == 2) begin
        checkOutput("fetch_m_rw", bus.m_rw, 0);
        checkOutput("fetch_m_addr", bus.m_addr, 9'h010);
      end
    end

    // Contention: data first, fetch follows once data drops its request.
    applyStimulus(1, 9'h008, 1, 0, 2'b10, 9'h030, 32'h0, c);
    expectAck(1'b1, 32'hCAFE0030, c + 3);
    expectAck(1'b0, 32'h33334444, c + 7);
    waitAck(1'b1);
    applyStimulus(1, 9'h008, 0, 0, 2'b10, 9'h030, 32'h0, c);
    @(negedge clk);
    checkOutput("cont_idle_m_en", bus.m_en, 0);
    @(negedge clk);
    checkOutput("cont_fetch_m_en", bus.m_en, 1);
    checkOutput("cont_fetch_m_addr", bus.m_addr, 9'h008);
    checkOutput("cont_fetch_m_size", bus.m_size, 2'b10);
    waitAck(1'b0);

    // Word write: m_* carry the store, d_rdata keeps the last load value.
    applyStimulus(0, 9'h0, 1, 1, 2'b10, 9'h020, 32'hDEADBEEF, c);
    expectAck(1'b1, 32'hCAFE0030, c + 3);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("wr_d_stall", bus.d_stall, 64'(k < 3));
      if (k == 1 || k == 2) begin
        checkOutput("wr_m_en", bus.m_en, 1);
        checkOutput("wr_m_rw", bus.m_rw, 1);
        checkOutput("wr_m_size", bus.m_size, 2'b10);
        checkOutput("wr_m_addr", bus.m_addr, 9'h020);
        checkOutput("wr_m_wdata", bus.m_wdata, 32'hDEADBEEF);
      end
    end

    // Both held: four data grants, then a forced fetch, then data again.
    applyStimulus(1, 9'h010, 1, 0, 2'b10, 9'h004, 32'h0, c);
    expectAck(1'b1, 32'h11112222, c + 3);
    expectAck(1'b1, 32'h11112222, c + 7);
    expectAck(1'b1, 32'h11112222, c + 11);
    expectAck(1'b1, 32'h11112222, c + 15);
    expectAck(1'b0, 32'h8C220004, c + 19);
    expectAck(1'b1, 32'h11112222, c + 23);
    repeat (23) @(posedge clk);
    @(negedge clk);
    applyStimulus(0, 9'h0, 0, 0, 2'b00, 9'h0, 32'h0, c);
`ifdef ARB_PERF_EN
    checkOutput("perf_forced_cnt", forced_cnt, 1);
`endif

    // Reset in the first ACCESS cycle aborts the fetch without an ack.
    applyStimulus(1, 9'h008, 0, 0, 2'b00, 9'h0, 32'h0, c);
    applyStimulus(0, 9'h0, 0, 0, 2'b00, 9'h0, 32'h0, c);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_m_en_before", bus.m_en, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("abort_m_en_after", bus.m_en, 0);
    checkOutput("abort_if_rdata", bus.if_rdata, 0);
    repeat (4) @(posedge clk);
    applyStimulus(1, 9'h010, 0, 0, 2'b00, 9'h0, 32'h0, c);
    expectAck(1'b0, 32'h8C220004, c + 3);
    waitAck(1'b0);
    applyStimulus(0, 9'h0, 0, 0, 2'b00, 9'h0, 32'h0, c);

    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("sb_drained", 64'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified single-port memory between the IF stage (instruction fetch, read-only) and the MEM stage (data load/store).
- Sequences each access over a fixed memory latency.
- Returns per-requester ack/data.
- Drives stall signals that the hazard logic uses to freeze PC/nPC and the pipeline registers.
- Data side has priority; a starvation guard bounds how long fetch can wait.

Parameters:
AW, 9, address width in bits (512-byte memory)
DW, 32, data width
MEM_LAT, 2, memory access latency in cycles, legal 1..15
STARVE_MAX, 4, consecutive contended data grants before fetch is forced, legal 1..15

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  synchronous, active-high reset
if_req  in  1  fetch request; held with if_addr until if_ack
if_addr  in  AW  fetch byte address
if_ack  out  1  one-cycle pulse; if_rdata valid in the same cycle
if_rdata  out  DW  fetched word; holds until the next fetch completes
d_req  in  1  data request; held with all d_* inputs until d_ack
d_rw  in  1  1=write, 0=read
d_size  in  2  00 byte, 01 halfword, 10 word
d_addr  in  AW  data byte address
d_wdata  in  DW  store data
d_ack  out  1  one-cycle pulse
d_rdata  out  DW  load data; holds until the next data read completes
m_en  out  1  memory enable, registered
m_rw  out  1  memory write strobe, registered
m_size  out  2  access size, registered
m_addr  out  AW  registered address
m_wdata  out  DW  registered write data
m_rdata  in  DW  memory read data, sampled on the last access cycle
if_stall  out  1  combinational: if_req & ~if_ack
d_stall  out  1  combinational: d_req & ~d_ack

Behaviour:
- Reset:
  - state=IDLE; starve_cnt=0; lat_cnt=0.
  - All outputs 0, including if_rdata and d_rdata.
  - Reset during ACCESS aborts the access: m_en=0 the next cycle, no ack is issued.
- FSM states are IDLE, ACCESS and ACK.
- IDLE:
  - If any request is high, pick a winner.
  - Latch the winner's fields into the m_* registers; a fetch latches m_rw=0 and m_size=10.
  - Set m_en=1, lat_cnt=MEM_LAT-1, go to ACCESS.
  - If no request is high, remain in IDLE with m_en=0.
- ACCESS:
  - m_* are held stable.
  - lat_cnt>0: decrement lat_cnt.
  - lat_cnt==0: for a read, capture m_rdata into the winner's rdata register; clear m_en and m_rw; go to ACK.
- ACK:
  - Pulse the winner's ack for one cycle.
  - Requests are ignored in this cycle.
  - Return to IDLE.
- Timing:
  - Request seen in cycle 0 → m_en high in cycles 1..MEM_LAT → ack in cycle MEM_LAT+1.
  - Throughput is one access per MEM_LAT+2 cycles.
- Arbitration, applied at the IDLE decision:
  - Data only: grant data.
  - Fetch only: grant fetch.
  - Both, with starve_cnt<STARVE_MAX: grant data and increment starve_cnt.
  - Both, with starve_cnt==STARVE_MAX: grant fetch.
  - starve_cnt clears on any fetch grant, or on any grant made while if_req=0.
- Writes leave d_rdata unchanged.
- if_rdata is never modified by data accesses, and d_rdata is never modified by fetches.
- A request dropped mid-access (protocol violation) does not abort the access; the ack still pulses.
- MEM_LAT=1: ACCESS lasts exactly one cycle.
- Address alignment is not checked; m_addr is passed through unmodified.

Optional Feature:
- Macro: ARB_PERF_EN.
- Defined:
  - Adds ports conflict_cnt (out, 16) and forced_cnt (out, 16).
  - conflict_cnt increments every cycle with if_req & d_req both high.
  - forced_cnt increments on each starvation-forced fetch grant.
  - Both counters saturate at 16'hFFFF and clear on reset.
- Undefined: the ports and logic are absent; the remaining behaviour is identical.

Test Plan:
- Reset held for 2 cycles, requests high → all outputs 0, m_en stays 0; after release, service starts from IDLE.
- Lone fetch, MEM_LAT=2, if_addr=0x010, m_rdata=0x8C220004 → m_en=1/m_rw=0 in cycles 1-2; if_ack in cycle 3 with if_rdata=0x8C220004; if_stall high in cycles 0-2, low in cycle 3.
- Both requesting in cycle 0; data requester drops d_req after d_ack → d_ack in cycle 3, m_en for the fetch in cycles 5-6, if_ack in cycle 7.
- d_req and if_req held high continuously, STARVE_MAX=4 → acks in order d,d,d,d,if,d,...; with ARB_PERF_EN, forced_cnt=1 after the if_ack.
- Write: d_rw=1, d_size=10, d_addr=0x020, d_wdata=0xDEADBEEF → m_rw=1, m_size=10, m_addr=0x020, m_wdata=0xDEADBEEF during ACCESS; d_ack pulses; d_rdata keeps its prior value.
- reset asserted in the first ACCESS cycle of a fetch → m_en=0 the next cycle, no if_ack; a fresh fetch after release completes normally in MEM_LAT+2 cycles.
